// File: rtl/registered_gate_unit.sv
// Registered bitwise gate stage: AND, NAND and NOR of two operands, plus one
// sel-chosen result, all with one cycle of latency and a valid strobe.
module registered_gate_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] nand_out,
    output logic [WIDTH-1:0] nor_out,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             sel_err
);

    typedef enum logic [1:0] {
        SEL_AND  = 2'b00,
        SEL_NAND = 2'b01,
        SEL_NOR  = 2'b10,
        SEL_RSVD = 2'b11
    } sel_t;

    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] nor_d;
    logic [WIDTH-1:0] result_d;
    logic             sel_err_d;

    always_comb begin
        and_d     = a & b;
        nand_d    = ~(a & b);
        nor_d     = ~(a | b);
        result_d  = '0;
        sel_err_d = 1'b0;
        case (sel_t'(sel))
            SEL_AND:  result_d = and_d;
            SEL_NAND: result_d = nand_d;
            SEL_NOR:  result_d = nor_d;
            SEL_RSVD: sel_err_d = 1'b1;
            default:  sel_err_d = 1'b1;
        endcase
    end

    // Reset wins over capture; with in_valid low only out_valid changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            and_out   <= '0;
            nand_out  <= '0;
            nor_out   <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                and_out  <= and_d;
                nand_out <= nand_d;
                nor_out  <= nor_d;
                result   <= result_d;
                sel_err  <= sel_err_d;
            end
        end
    end

endmodule

// File: tb/tb_registered_gate_unit.sv
// Directed bench for registered_gate_unit using a 1-bit and an 8-bit instance
// that share clock, reset, valid and select.
module tb_registered_gate_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] sel;

    logic [0:0] a1, b1, and1, nand1, nor1, res1;
    logic       ov1, err1;
    logic [7:0] a8, b8, and8, nand8, nor8, res8;
    logic       ov8, err8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    registered_gate_unit #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid), .sel(sel),
        .and_out(and1), .nand_out(nand1), .nor_out(nor1), .result(res1),
        .out_valid(ov1), .sel_err(err1)
    );

    registered_gate_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid), .sel(sel),
        .and_out(and8), .nand_out(nand8), .nor_out(nor8), .result(res8),
        .out_valid(ov8), .sel_err(err8)
    );

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; sel = 2'b00;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        step();
        step();
        tests++;
        if ({and1, nand1, nor1, res1, ov1, err1} !== 6'b0) begin
            fails++;
            $display("FAIL reset_w1: got %b required 000000", {and1, nand1, nor1, res1, ov1, err1});
        end
        tests++;
        if ({and8, nand8, nor8, res8, ov8, err8} !== 34'b0) begin
            fails++;
            $display("FAIL reset_w8: got %h required 0", {and8, nand8, nor8, res8, ov8, err8});
        end
        rst_n = 1'b1;
        step();
        tests++;
        if ({and1, nand1, nor1, res1, ov1, err1} !== 6'b011010) begin
            fails++;
            $display("FAIL reset_release_w1: got %b required 011010", {and1, nand1, nor1, res1, ov1, err1});
        end
        tests++;
        if ({and8, nand8, nor8, ov8} !== {8'h00, 8'hFF, 8'hFF, 1'b1}) begin
            fails++;
            $display("FAIL reset_release_w8: got %h/%h/%h/%b required 00/ff/ff/1", and8, nand8, nor8, ov8);
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] exp [4];
        logic [1:0] ab;
        exp[0] = 3'b011; exp[1] = 3'b010; exp[2] = 3'b010; exp[3] = 3'b100;
        in_valid = 1'b1; sel = 2'b00;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            step();
            tests++;
            if ({and1, nand1, nor1, ov1, res1} !== {exp[i], 1'b1, exp[i][2]}) begin
                fails++;
                $display("FAIL exhaustive_ab%b: got and/nand/nor/ov/res %b required %b",
                         ab, {and1, nand1, nor1, ov1, res1}, {exp[i], 1'b1, exp[i][2]});
            end
        end
    endtask

    task automatic test_select();
        logic exp_res [4];
        exp_res[0] = 1'b0; exp_res[1] = 1'b1; exp_res[2] = 1'b0; exp_res[3] = 1'b0;
        in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step();
            tests++;
            if ({res1, err1} !== {exp_res[s], (s == 3)}) begin
                fails++;
                $display("FAIL select_%0d: got res/err %b required %b", s, {res1, err1}, {exp_res[s], (s == 3)});
            end
        end
        sel = 2'b01;
        step();
        tests++;
        if ({res1, err1} !== 2'b10) begin
            fails++;
            $display("FAIL select_err_clear: got res/err %b required 10", {res1, err1});
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; sel = 2'b00; a1 = 1'b1; b1 = 1'b1;
        step();
        in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; sel = 2'b10;
        step();
        step();
        tests++;
        if ({and1, nand1, nor1, res1, ov1, err1} !== 6'b100100) begin
            fails++;
            $display("FAIL hold: got %b required 100100", {and1, nand1, nor1, res1, ov1, err1});
        end
        in_valid = 1'b1; sel = 2'b11;
        step();
        in_valid = 1'b0; sel = 2'b00;
        step();
        tests++;
        if ({res1, ov1, err1} !== 3'b001) begin
            fails++;
            $display("FAIL hold_sel_err: got res/ov/err %b required 001", {res1, ov1, err1});
        end
    endtask

    task automatic test_width8();
        in_valid = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
        sel = 2'b00;
        step();
        tests++;
        if ({and8, nand8, nor8, res8, ov8} !== {8'hC0, 8'h3F, 8'h03, 8'hC0, 1'b1}) begin
            fails++;
            $display("FAIL width8_gates: got %h/%h/%h/%h/%b required c0/3f/03/c0/1", and8, nand8, nor8, res8, ov8);
        end
        sel = 2'b01;
        step();
        tests++;
        if (res8 !== 8'h3F) begin
            fails++;
            $display("FAIL width8_sel_nand: got %h required 3f", res8);
        end
        sel = 2'b10; a8 = 8'h5A; b8 = 8'h0F;
        step();
        tests++;
        if ({and8, nand8, nor8, res8} !== {8'h0A, 8'hF5, 8'hA0, 8'hA0}) begin
            fails++;
            $display("FAIL width8_sel_nor: got %h/%h/%h/%h required 0a/f5/a0/a0", and8, nand8, nor8, res8);
        end
        tests++;
        if (nand8 !== ~and8 || (nor8 & and8) !== 8'h00 || (nor8 & ~nand8) !== 8'h00) begin
            fails++;
            $display("FAIL width8_invariants: got and %h nand %h nor %h required consistent", and8, nand8, nor8);
        end
    endtask

    task automatic test_midstream_reset();
        in_valid = 1'b1; sel = 2'b00; a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        rst_n = 1'b0;
        step();
        tests++;
        if ({and1, ov1, and8, ov8} !== 10'b0) begin
            fails++;
            $display("FAIL midstream_reset: got and1/ov1/and8/ov8 %b/%b/%h/%b required 0/0/00/0", and1, ov1, and8, ov8);
        end
        rst_n = 1'b1;
        step();
        tests++;
        if ({and1, ov1, and8, ov8} !== {1'b1, 1'b1, 8'hFF, 1'b1}) begin
            fails++;
            $display("FAIL midstream_recover: got and1/ov1/and8/ov8 %b/%b/%h/%b required 1/1/ff/1", and1, ov1, and8, ov8);
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_select();
        test_hold();
        test_width8();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
